// File: rtl/contador_pkg.sv
// Shared types and opcodes for the counter sequencer.
// State encoding is visible on state_o for debug.
package contador_pkg;

  localparam int CNT_WIDTH = 12;
  localparam int PRESC_W   = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  localparam logic [2:0] OP_SET_TERM  = 3'b000;
  localparam logic [2:0] OP_SET_DIV   = 3'b001;
  localparam logic [2:0] OP_START_ONE = 3'b010;
  localparam logic [2:0] OP_START_RLD = 3'b011;
  localparam logic [2:0] OP_PAUSE     = 3'b100;
  localparam logic [2:0] OP_RESUME    = 3'b101;
  localparam logic [2:0] OP_ABORT     = 3'b110;
  localparam logic [2:0] OP_NOP       = 3'b111;

endpackage

// File: rtl/contador_prescaler.sv
// Tick generator: one tick every div+1 enabled cycles.
// The divisor is sampled on clear and on each wrap.
module contador_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             hold_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    tick_o = (cnt_q == div_q);
    cnt_d  = cnt_q;
    div_d  = div_q;
    if (clr_i) begin
      cnt_d = '0;
      div_d = div_i;
    end else if (!hold_i) begin
      if (tick_o) begin
        cnt_d = '0;
        div_d = div_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      div_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/contador_sequencer.sv
// Command-driven run controller for a loadable up-counter.
// Sequences load/enable strobes and flags terminal count.
module contador_sequencer
  import contador_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH,
  parameter int DIV_W = PRESC_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] cnt_val,
  output logic             cnt_en,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             done,
  output logic             busy,
  output logic [2:0]       state_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic             reload_q, reload_d;

  logic tick;
  logic acc;
  logic at_term;
  logic run;

  contador_prescaler #(
    .DIV_W (DIV_W)
  ) u_presc (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (state_q == S_LOAD),
    .hold_i (state_q != S_RUN),
    .div_i  (div_q),
    .tick_o (tick)
  );

  always_comb begin
    state_d  = state_q;
    term_d   = term_q;
    div_d    = div_q;
    start_d  = start_q;
    reload_d = reload_q;

    run     = (state_q == S_RUN);
    at_term = (cnt_val == term_q);

    cmd_ready    = (state_q != S_LOAD);
    acc          = cmd_valid && cmd_ready;
    cnt_load     = (state_q == S_LOAD);
    cnt_load_val = cnt_load ? start_q : '0;
    cnt_en       = run && tick && !at_term;
    done         = run && at_term;
    busy         = (state_q == S_LOAD) ||
                   (state_q == S_RUN)  ||
                   (state_q == S_PAUSE);
    state_o      = state_q;

    case (state_q)
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        if (at_term)
          state_d = reload_q ? S_LOAD : S_DONE;
      end
      default: ;
    endcase

    // Accepted commands override the terminal-count transition.
    if (acc) begin
      case (cmd_op)
        OP_SET_TERM: term_d = cmd_data;
        OP_SET_DIV:  div_d  = cmd_data[DIV_W-1:0];
        OP_START_ONE, OP_START_RLD: begin
          start_d  = cmd_data;
          reload_d = cmd_op[0];
          state_d  = S_LOAD;
        end
        OP_PAUSE: begin
          if (state_q == S_RUN)
            state_d = S_PAUSE;
        end
        OP_RESUME: begin
          if (state_q == S_PAUSE)
            state_d = S_RUN;
        end
        OP_ABORT: begin
          if (state_q == S_RUN ||
              state_q == S_PAUSE ||
              state_q == S_DONE)
            state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      term_q   <= '1;
      div_q    <= '0;
      start_q  <= '0;
      reload_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      term_q   <= term_d;
      div_q    <= div_d;
      start_q  <= start_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: tb/tb_contador_sequencer.sv
// Bench for contador_sequencer with a behavioural 12-bit counter
// and an arithmetic reference model of run timing.
module tb_contador_sequencer;
  import contador_pkg::*;

  localparam int P_IDLE  = 0;
  localparam int P_LOAD  = 1;
  localparam int P_RUN   = 2;
  localparam int P_PAUSE = 3;
  localparam int P_DONE  = 4;

  logic        clk;
  logic        rst;
  logic        cnt_rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [11:0] cmd_data;
  logic [11:0] cnt_val;
  logic        cnt_en;
  logic        cnt_load;
  logic [11:0] cnt_load_val;
  logic        done;
  logic        busy;
  logic [2:0]  state_o;

  int n_vec = 0;
  int n_err = 0;

  int m_ph, m_term, m_div, m_start, m_rel;
  int m_r, m_dr, m_cnt;
  bit dut_done;

  contador_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cnt_val      (cnt_val),
    .cnt_en       (cnt_en),
    .cnt_load     (cnt_load),
    .cnt_load_val (cnt_load_val),
    .done         (done),
    .busy         (busy),
    .state_o      (state_o)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (cnt_rst)       cnt_val <= '0;
    else if (cnt_load) cnt_val <= cnt_load_val;
    else if (cnt_en)   cnt_val <= cnt_val + 12'd1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_ph    = P_IDLE;
    m_term  = 'hFFF;
    m_div   = 0;
    m_start = 0;
    m_rel   = 0;
    m_r     = 0;
    m_dr    = 0;
  endtask

  // Called at a negedge: drive, check this cycle, advance model one clock.
  task automatic step(input bit v, input logic [2:0] op,
                      input logic [11:0] d);
    int  k, nph;
    bit  run, en, dn, acc;
    cmd_valid = v;
    cmd_op    = op;
    cmd_data  = d;
    #1;
    run = (m_ph == P_RUN);
    k   = (m_term - m_start) & 'hFFF;
    en  = run && (((m_r + 1) % (m_dr + 1)) == 0) &&
          ((m_r / (m_dr + 1)) < k);
    dn  = run && (m_r >= k * (m_dr + 1));
    chk("state", 32'(state_o), m_ph);
    chk("ready", 32'(cmd_ready), 32'(m_ph != P_LOAD));
    chk("busy", 32'(busy), 32'(m_ph inside {P_LOAD, P_RUN, P_PAUSE}));
    chk("cnt_en", 32'(cnt_en), 32'(en));
    chk("cnt_load", 32'(cnt_load), 32'(m_ph == P_LOAD));
    chk("load_val", 32'(cnt_load_val), (m_ph == P_LOAD) ? m_start : 0);
    chk("done", 32'(done), 32'(dn));
    chk("cnt_val", 32'(cnt_val), m_cnt);
    dut_done = done;
    acc = v && (m_ph != P_LOAD);
    if (en) m_cnt = (m_cnt + 1) & 'hFFF;
    nph = m_ph;
    if (m_ph == P_LOAD) begin
      nph   = P_RUN;
      m_r   = 0;
      m_dr  = m_div;
      m_cnt = m_start;
    end else if (run) begin
      m_r = m_r + 1;
    end
    if (acc) begin
      case (op)
        OP_SET_TERM: m_term = int'(d);
        OP_SET_DIV:  m_div = int'(d[7:0]);
        OP_START_ONE, OP_START_RLD: begin
          m_start = int'(d);
          m_rel   = int'(op[0]);
          nph     = P_LOAD;
        end
        OP_PAUSE:  if (m_ph == P_RUN) nph = P_PAUSE;
        OP_RESUME: if (m_ph == P_PAUSE) nph = P_RUN;
        OP_ABORT:
          if (m_ph inside {P_RUN, P_PAUSE, P_DONE}) nph = P_IDLE;
        default: ;
      endcase
    end
    if (run && dn && nph == P_RUN)
      nph = m_rel ? P_LOAD : P_DONE;
    m_ph = nph;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_until_done(input int lim, output int n);
    n = 0;
    dut_done = 0;
    while (!dut_done && n < lim) begin
      step(0, OP_NOP, 12'h0);
      n++;
    end
    chk("done_seen", 32'(dut_done), 1);
  endtask

  initial begin
    int n, g, d, t, s, pick;
    bit v;
    logic [2:0]  op;
    logic [11:0] dat;

    clk = 0;
    rst = 1;
    cnt_rst = 1;
    cmd_valid = 0;
    cmd_op = OP_NOP;
    cmd_data = '0;
    model_reset();
    m_cnt = 0;
    dut_done = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    cnt_rst = 0;
    step(0, OP_NOP, 12'h0);

    // reset mid-run at 0x010
    step(1, OP_SET_TERM, 12'h020);
    step(1, OP_START_ONE, 12'h000);
    g = 0;
    while (m_cnt != 'h010 && g < 100) begin
      step(0, OP_NOP, 12'h0);
      g++;
    end
    chk("t1_reach", 32'(cnt_val), 'h010);
    rst = 1;
    model_reset();
    step(0, OP_NOP, 12'h0);
    rst = 0;
    step(0, OP_NOP, 12'h0);
    chk("t1_val", 32'(cnt_val), 'h010);

    // one-shot 0 -> 5
    step(1, OP_SET_TERM, 12'h005);
    step(1, OP_START_ONE, 12'h000);
    run_until_done(50, n);
    chk("t2_lat", n, 7);
    repeat (3) step(0, OP_NOP, 12'h0);
    chk("t2_hold", 32'(cnt_val), 'h005);
    chk("t2_state", 32'(state_o), P_DONE);

    // wrap-around auto-reload
    step(1, OP_SET_TERM, 12'h002);
    step(1, OP_START_RLD, 12'hFFE);
    run_until_done(50, n);
    chk("t3_first", n, 6);
    repeat (2) begin
      run_until_done(50, n);
      chk("t3_period", n, 6);
    end
    step(0, OP_NOP, 12'h0);
    step(1, OP_ABORT, 12'h0);

    // prescaled one-shot
    step(1, OP_SET_DIV, 12'h003);
    step(1, OP_SET_TERM, 12'h002);
    step(1, OP_START_ONE, 12'h000);
    run_until_done(100, n);
    chk("t4_lat", n, 10);

    // pause and resume at 0x003
    step(1, OP_SET_TERM, 12'h008);
    step(1, OP_START_ONE, 12'h000);
    g = 0;
    while (m_cnt != 3 && g < 100) begin
      step(0, OP_NOP, 12'h0);
      g++;
    end
    step(1, OP_PAUSE, 12'h0);
    repeat (10) step(0, OP_NOP, 12'h0);
    chk("t5_hold", 32'(cnt_val), 'h003);
    step(1, OP_RESUME, 12'h0);
    run_until_done(200, n);
    chk("t5_end", 32'(cnt_val), 'h008);

    // abort on terminal cycle, then term == start
    step(1, OP_SET_DIV, 12'h000);
    step(1, OP_SET_TERM, 12'h003);
    step(1, OP_START_ONE, 12'h000);
    repeat (4) step(0, OP_NOP, 12'h0);
    step(1, OP_ABORT, 12'h0);
    chk("t6_done", 32'(dut_done), 1);
    chk("t6_idle", 32'(state_o), P_IDLE);
    step(1, OP_SET_TERM, 12'h007);
    step(1, OP_START_ONE, 12'h007);
    run_until_done(20, n);
    chk("t6_eq", n, 2);

    // randomized runs with pause/resume/restart/abort traffic
    for (int it = 0; it < 60; it++) begin
      g = 0;
      while (m_ph != P_IDLE && g < 5) begin
        step(1, OP_ABORT, 12'h0);
        g++;
      end
      d = $urandom_range(0, 3);
      t = $urandom_range(0, 'hFFF);
      s = (t - $urandom_range(0, 12)) & 'hFFF;
      step(1, OP_SET_DIV, 12'(d));
      step(1, OP_SET_TERM, 12'(t));
      op = ($urandom_range(0, 1) != 0) ? OP_START_RLD : OP_START_ONE;
      step(1, op, 12'(s));
      repeat ($urandom_range(10, 80)) begin
        pick = $urandom_range(0, 19);
        v = 1;
        dat = 12'($urandom_range(0, 'hFFF));
        case (pick)
          0, 1: op = OP_PAUSE;
          2, 3: op = OP_RESUME;
          4: begin
            op = ($urandom_range(0, 1) != 0) ? OP_START_RLD : OP_START_ONE;
            dat = 12'((m_term - $urandom_range(0, 12)) & 'hFFF);
          end
          5: op = OP_ABORT;
          6: op = OP_NOP;
          default: begin
            v = 0;
            op = OP_SET_TERM;
          end
        endcase
        step(v, op, dat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
